// File: rtl/sap1_pkg.sv
// Shared SAP-1 constants: bus widths, opcodes and the demo program image
// that sap_ram loads on reset when SAP1_RAM_PRELOAD_EN is defined.
package sap1_pkg;

    localparam int SAP1_ADDR_W = 4;
    localparam int SAP1_DATA_W = 8;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // LDA 9, ADD A, ADD B, SUB C, OUT, HLT, then operands at 9..C
    localparam logic [7:0] SAP1_PRELOAD [16] = '{
        {OP_LDA, 4'h9}, {OP_ADD, 4'hA}, {OP_ADD, 4'hB}, {OP_SUB, 4'hC},
        {OP_OUT, 4'h0}, {OP_HLT, 4'h0}, 8'h00,          8'h00,
        8'h00,          8'h10,          8'h14,          8'h18,
        8'h04,          8'h00,          8'h00,          8'h00
    };

    function automatic logic [7:0] preload_word(input int idx);
        if (idx < 16)
            return SAP1_PRELOAD[idx[3:0]];
        else
            return 8'h00;
    endfunction

endpackage

// File: rtl/sap_ram_wr_pulse.sv
// wr_pulse: synchronizes an asynchronous manual switch and emits a one-cycle
// rising-edge pulse. Flops reset high so a switch held through reset is ignored.
module wr_pulse (
    input  logic CLK,
    input  logic CLR,
    input  logic WR,
    output logic wr_edge
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= WR;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign wr_edge = s2 & ~s3;

endmodule

// File: rtl/sap_ram.sv
// sap_ram: SAP-1 16x8 program/data memory with debounced manual write and
// combinational read. Define SAP1_RAM_PRELOAD_EN to load the demo program on CLR.
module sap_ram
    import sap1_pkg::*;
#(
    parameter int ADDR_W = SAP1_ADDR_W,
    parameter int DATA_W = SAP1_DATA_W
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] D,
    input  logic              PROG,
    input  logic              WR,
    input  logic              CE,
    output logic [DATA_W-1:0] W_OUT,
    output logic              W_OE,
    output logic              WR_ACK
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_edge;
    logic              do_write;

    wr_pulse u_wr_pulse (
        .CLK     (CLK),
        .CLR     (CLR),
        .WR      (WR),
        .wr_edge (wr_edge)
    );

    // An edge seen outside program mode is simply dropped, never deferred
    assign do_write = wr_edge & PROG;

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            for (int i = 0; i < DEPTH; i++) begin
`ifdef SAP1_RAM_PRELOAD_EN
                mem[i[ADDR_W-1:0]] <= DATA_W'(preload_word(i));
`else
                mem[i[ADDR_W-1:0]] <= '0;
`endif
            end
            WR_ACK <= 1'b0;
        end else begin
            WR_ACK <= do_write;
            if (do_write)
                mem[ADDR] <= D;
        end
    end

    assign W_OUT = mem[ADDR];
    assign W_OE  = CE & ~PROG;

endmodule

// File: tb/tb_sap_ram.sv
// Self-checking bench for sap_ram: directed button sequences plus randomized
// presses, compared against a simple array model of the memory contents.
module tb_sap_ram;

    logic       CLK = 1'b0;
    logic       CLR;
    logic [3:0] ADDR;
    logic [7:0] D;
    logic       PROG;
    logic       WR;
    logic       CE;
    logic [7:0] W_OUT;
    logic       W_OE;
    logic       WR_ACK;

    int         checks_total  = 0;
    int         checks_passed = 0;
    logic [7:0] ref_mem [16];

    sap_ram dut (
        .CLK    (CLK),
        .CLR    (CLR),
        .ADDR   (ADDR),
        .D      (D),
        .PROG   (PROG),
        .WR     (WR),
        .CE     (CE),
        .W_OUT  (W_OUT),
        .W_OE   (W_OE),
        .WR_ACK (WR_ACK)
    );

    always #5 CLK = ~CLK;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Contents the memory must hold right after CLR
    task automatic reset_model();
        logic [7:0] image [16];
`ifdef SAP1_RAM_PRELOAD_EN
        image = '{8'h09, 8'h1A, 8'h1B, 8'h2C, 8'hE0, 8'hF0, 8'h00, 8'h00,
                  8'h00, 8'h10, 8'h14, 8'h18, 8'h04, 8'h00, 8'h00, 8'h00};
`else
        image = '{default: 8'h00};
`endif
        for (int i = 0; i < 16; i++) ref_mem[i] = image[i];
    endtask

    task automatic read_all(input string tag);
        PROG = 1'b0;
        CE   = 1'b1;
        for (int a = 0; a < 16; a++) begin
            ADDR = 4'(a);
            #1;
            check_output($sformatf("%s word[%0d]", tag, a), W_OUT, ref_mem[a]);
            check_output($sformatf("%s oe[%0d]", tag, a), W_OE, 1'b1);
        end
    endtask

    task automatic release_wr();
        WR = 1'b0;
        repeat (3) tick();
    endtask

    // One button press held for 'hold' cycles; ack and write land on edge 3.
    // ADDR/D are scrambled after the write edge and must not disturb contents.
    task automatic apply_stimulus(input logic [3:0] a, input logic [7:0] d, input logic p,
                                  input int hold, input string tag);
        ADDR = a;
        D    = d;
        PROG = p;
        WR   = 1'b1;
        for (int c = 1; c <= hold; c++) begin
            tick();
            check_output($sformatf("%s ack@%0d", tag, c), WR_ACK, (c == 3) && p);
            if (c == 3) begin
                if (p) ref_mem[a] = d;
                check_output($sformatf("%s raw", tag), W_OUT, ref_mem[a]);
            end
            if (c >= 4) begin
                ADDR = 4'($urandom);
                D    = 8'($urandom);
            end
        end
        release_wr();
    endtask

    initial begin
        CLR  = 1'b1;
        WR   = 1'b0;
        PROG = 1'b0;
        CE   = 1'b1;
        ADDR = 4'h0;
        D    = 8'h00;
        reset_model();
        #1;
        check_output("reset ack", WR_ACK, 1'b0);
        tick();
        tick();
        CLR = 1'b0;
        read_all("reset");

        // Long press in program mode
        apply_stimulus(4'h3, 8'hA5, 1'b1, 20, "hold20");
        PROG = 1'b0;
        CE   = 1'b1;
        ADDR = 4'h3;
        #1;
        check_output("rd3 word", W_OUT, 8'hA5);
        check_output("rd3 oe", W_OE, 1'b1);

        // Edge in run mode is consumed; raising PROG later must not write
        PROG = 1'b0;
        ADDR = 4'h5;
        D    = 8'hFF;
        WR   = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            check_output($sformatf("run edge ack@%0d", c), WR_ACK, 1'b0);
            if (c == 6) PROG = 1'b1;
        end
        release_wr();
        read_all("run edge");

        // PROG falling after edge 1 blocks the write
        apply_stimulus(4'h6, 8'h11, 1'b1, 0, "dummy");
        PROG = 1'b1;
        ADDR = 4'h6;
        D    = 8'h66;
        WR   = 1'b1;
        tick();
        PROG = 1'b0;
        for (int c = 2; c <= 8; c++) begin
            tick();
            check_output($sformatf("prog fall ack@%0d", c), WR_ACK, 1'b0);
        end
        release_wr();
        read_all("prog fall");

        // Button held through CLR produces no write after release
        PROG = 1'b1;
        ADDR = 4'h7;
        D    = 8'h3C;
        WR   = 1'b1;
        CLR  = 1'b1;
        reset_model();
        tick();
        tick();
        check_output("held clr ack", WR_ACK, 1'b0);
        CLR = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            check_output($sformatf("held after clr ack@%0d", c), WR_ACK, 1'b0);
        end
        release_wr();
        read_all("held clr");
        apply_stimulus(4'h7, 8'h3C, 1'b1, 6, "repress");
        read_all("repress");

        // CLR in the middle of a press aborts it
        PROG = 1'b1;
        ADDR = 4'h2;
        D    = 8'h77;
        WR   = 1'b1;
        tick();
        tick();
        #2;
        CLR = 1'b1;
        reset_model();
        #1;
        check_output("abort ack", WR_ACK, 1'b0);
        tick();
        CLR = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            tick();
            check_output($sformatf("abort after ack@%0d", c), WR_ACK, 1'b0);
        end
        release_wr();
        read_all("abort");

        // Fill every address with ADDR ^ 5A
        for (int a = 0; a < 16; a++)
            apply_stimulus(4'(a), 8'(a) ^ 8'h5A, 1'b1, 4, $sformatf("fill%0d", a));
        read_all("fill");
        for (int a = 0; a < 16; a++) begin
            ADDR = 4'(a);
            #1;
            check_output($sformatf("fill pattern[%0d]", a), W_OUT, 8'(a) ^ 8'h5A);
        end

        // Bus enable truth table
        for (int ce = 0; ce < 2; ce++) begin
            for (int p = 0; p < 2; p++) begin
                CE   = ce[0];
                PROG = p[0];
                #1;
                check_output($sformatf("oe ce=%0d prog=%0d", ce, p), W_OE, ce[0] & ~p[0]);
            end
        end

        // Randomized presses, mostly in program mode
        for (int n = 0; n < 24; n++) begin
            apply_stimulus(4'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0),
                           $urandom_range(4, 9), $sformatf("rand%0d", n));
        end
        read_all("random");

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/sap_ram.md
# sap_ram

16 x 8 program/data memory for the SAP-1. It sits directly downstream of the address multiplexor: the mux output drives `ADDR`. In program mode, a debounced manual write stores the data switches at the selected address. In run mode, the addressed word drives the W bus when enabled.

## Interface
- `ADDR_W`, 4, address width; depth = 2**ADDR_W
- `DATA_W`, 8, word width
- `CLK`  input  1  system clock, rising-edge active
- `CLR`  input  1  reset, asynchronous, active-high
- `ADDR`  input  ADDR_W  address from the multiplexor output `Y`
- `D`  input  DATA_W  data switches, the write data
- `PROG`  input  1  1 = program mode (writes allowed, bus drive off); 0 = run mode
- `WR`  input  1  manual write button, level, asynchronous to `CLK`
- `CE`  input  1  run-mode read enable onto the W bus
- `W_OUT`  output  DATA_W  addressed word
- `W_OE`  output  1  bus drive enable
- `WR_ACK`  output  1  one-cycle pulse: a write occurred

## Operation
- Storage: array `mem[0:2**ADDR_W-1]` of DATA_W flops.
- Write path:
  - `WR` passes through sync flops `s1`, `s2`, then history flop `s3`.
  - `edge = s2 & ~s3`.
  - At the first `CLK` edge where `edge & PROG` is true: `mem[ADDR] <= D` and `WR_ACK <= 1`.
  - `WR_ACK` returns to 0 on the next edge.
- One write per button press, no matter how long `WR` is held. No auto-repeat.
- Edge while `PROG` = 0: no write, no ack. The edge is consumed and is not deferred.
- Read path is combinational:
  - `W_OUT = mem[ADDR]`.
  - `W_OE = CE & ~PROG`.
  - `W_OUT` is valid regardless of `W_OE`.
- `ADDR` and `D` are sampled only at the write edge. Changes at any other time have no effect on contents.
- All address values are valid. There is no out-of-range case and no wrap logic.

## Timing
- Reset values while `CLR` is high:
  - `s1`, `s2`, `s3` = 1. A button held through reset therefore produces no write after release.
  - `WR_ACK` = 0.
  - `mem` = all zero, or the preload image (see Configuration).
  - `W_OE` follows `CE & ~PROG`, since it is combinational.
- Write latency, counting `CLK` edges from the first edge that samples `WR` = 1:
  - edge 1: `s1` = 1
  - edge 2: `s2` = 1, `edge` asserts
  - edge 3: memory written and `WR_ACK` = 1; `s3` = 1
  - edge 4: `WR_ACK` = 0
- Read-after-write: `W_OUT` shows the new word combinationally after edge 3 when `ADDR` is unchanged.
- `PROG` is evaluated at edge 3 only. If `PROG` falls between edges 1 and 3, there is no write.
- `CLR` asserted mid-sequence: the write is aborted immediately and `WR_ACK` is cleared. After release, a new 0 -> 1 transition of `WR` is required.
- `WR` pulses shorter than one `CLK` period may be missed. This is acceptable for a manual button.

## Configuration
- Macro: `SAP1_RAM_PRELOAD_EN`.
- Defined: `CLR` loads the demo program.
  - Addresses 0..5: 09, 1A, 1B, 2C, E0, F0 (LDA 9, ADD A, ADD B, SUB C, OUT, HLT).
  - Addresses 9..C: 10, 14, 18, 04.
  - All other addresses: 00.
- Not defined: `CLR` zeroes all words.
- All other behaviour is identical in both builds.

## Structure
- Shared package `sap1_pkg` holds:
  - `SAP1_ADDR_W` = 4 and `SAP1_DATA_W` = 8
  - opcode constants: LDA = 0, ADD = 1, SUB = 2, OUT = E, HLT = F
  - the 16-entry preload image as a constant array
- One sub-module, `wr_pulse`: the 3-flop synchronizer plus edge detector. It has inputs `CLK`, `CLR`, `WR` and output `edge`. It is reusable for other manual switches.

## Test plan
- Reset, then read addresses 0..F with `PROG` = 0 and `CE` = 1. Required: `W_OE` = 1 and `W_OUT` = 00 at every address. With `SAP1_RAM_PRELOAD_EN` defined, `W_OUT` = 09, 1A, 1B, 2C, E0, F0, 00, 00, 00, 10, 14, 18, 04, 00, 00, 00.
- `PROG` = 1, `ADDR` = 3, `D` = A5, `WR` high for 20 cycles. Required: `WR_ACK` high exactly one cycle, on edge 3, and `mem[3]` = A5. Then `PROG` = 0, `CE` = 1, `ADDR` = 3. Required: `W_OUT` = A5, `W_OE` = 1.
- Edge with `PROG` = 0, `ADDR` = 5, `D` = FF. Required: no `WR_ACK` and `mem[5]` unchanged. Then set `PROG` = 1 while `WR` is still held. Required: no write.
- `WR` held high across `CLR` assertion and release. Required: no write after release. Then release and re-press with `ADDR` = 7, `D` = 3C. Required: `mem[7]` = 3C.
- Write all 16 addresses with `D = ADDR ^ 8'h5A`, then read back. Required: every word matches. Also toggle `CE`/`PROG` and check `W_OE = CE & ~PROG` for all 4 combinations.
